servo_pwm_capture: RTL and testbench
====================================

// Module: servo_pwm_capture
// PURPOSE
// - Receive side of the servo PWM link: measures high time and period of one servo-style PWM input.
// - Converts the pulse width back to an 8-bit angle (0-180), the inverse of pwm_generator's mapping.
// - Used for loopback self-test of servo outputs and for reading external RC/servo command signals.
// - Sits beside the pwm_generator instances in the robotic-arm top level, on CLOCK_50.
// PARAMETERS
// - MIN_PULSE      50_000     cycles of high time mapping to angle 0 (1.0 ms @ 50 MHz)
// - CYCLES_PER_DEG 278        cycles of high time per degree; angle 180 = MIN_PULSE + 180*278 = 100_040
// - TIMEOUT        2_000_000  cycles with no edge before timeout error (40 ms)
// - CNT_W          21         width of width/period counters; must hold TIMEOUT
// PORTS
// - CLOCK_50     in   1      system clock, 50 MHz
// - reset_n      in   1      asynchronous active-low reset
// - pwm_in       in   1      asynchronous PWM input, active high
// - angle        out  8      last decoded angle, 0..180
// - angle_valid  out  1      one-cycle strobe: angle/pulse_width/err_range just updated
// - pulse_width  out  CNT_W  last measured high time, cycles
// - period       out  CNT_W  last measured rising-to-rising period, cycles
// - err_range    out  1      last pulse outside [MIN_PULSE, MIN_PULSE+180*CYCLES_PER_DEG]
// - err_timeout  out  1      sticky: no edge for TIMEOUT cycles; clears on next angle_valid
// - busy         out  1      high while the divider is running
// BEHAVIOUR
// - Reset: angle=90, angle_valid=0, pulse_width=0, period=0, err_range=0, err_timeout=0, busy=0, FSM=SYNC.
// - Input: 2-flop synchronizer then edge detect; edges are seen 3 cycles after the pin changes.
// - Measurement FSM:
//   - SYNC: ignore input until first rising edge (partial pulse after reset/timeout is discarded) -> HIGH.
//   - HIGH: width counter from 1 on rising edge; on falling edge latch width, start divider -> LOW.
//   - LOW: wait; on rising edge -> HIGH, restart width count.
//   - Any state except SYNC: no edge for TIMEOUT cycles -> err_timeout=1, divider aborted, busy=0, -> SYNC.
// - Period counter runs from every rising edge; at the next rising edge period <= count; first rising
//   edge after SYNC does not update period. Counters saturate at 2^CNT_W-1, never wrap.
// - Divider (sequential, restoring subtraction, one subtract per cycle):
//   - w < MIN_PULSE: result 0, err_range=1, no iterations.
//   - w > MIN_PULSE+180*CYCLES_PER_DEG: result 180, err_range=1, no iterations.
//   - else result = floor((w-MIN_PULSE)/CYCLES_PER_DEG), err_range=0; at most 181 cycles.
//   - Done: angle, pulse_width, err_range update together; angle_valid pulses 1 cycle; err_timeout clears.
//   - Out-of-range result: 1 cycle after falling edge seen. In-range: q+2 cycles after falling edge seen.
// - Divider runs in parallel with LOW/HIGH; a new falling edge while busy aborts and restarts with new width.
// - busy=1 from divider start to the cycle angle_valid fires (exclusive).
// - Outputs hold last values between updates; angle never exceeds 180.
// - Reset mid-pulse or mid-divide: all state returns to reset values immediately (async).
// TESTING
// - 50 Hz, high 75_000: angle_valid once per period, angle=89, pulse_width=75_000, period=1_000_000.
// - High 50_000 -> angle=0, err_range=0; high 100_040 -> angle=180, err_range=0.
// - High 40_000 -> angle=0, err_range=1; high 120_000 -> angle=180, err_range=1; no divider iterations.
// - pwm_in held low 2_000_000 cycles -> err_timeout=1, angle holds; next full pulse -> err_timeout=0.
// - Reset released while pwm_in high: that pulse produces no angle_valid; first strobe is after next full pulse.
// - Loopback from pwm_generator, angles 0,45,90,135,180 -> decoded angle within +-1 of commanded value.

Source files
------------

// File: rtl/servo_pwm_capture_if.sv
// Signal bundle between the servo PWM capture block and its consumer:
// the PWM pin going in, the decoded angle and measurement results coming out.
interface servo_pwm_capture_if #(
  parameter int CNT_W = 21
);
  logic             pwm_in;
  logic [7:0]       angle;
  logic             angle_valid;
  logic [CNT_W-1:0] pulse_width;
  logic [CNT_W-1:0] period;
  logic             err_range;
  logic             err_timeout;
  logic             busy;

  modport master (
    output pwm_in,
    input  angle, angle_valid, pulse_width, period, err_range, err_timeout, busy
  );

  modport slave (
    input  pwm_in,
    output angle, angle_valid, pulse_width, period, err_range, err_timeout, busy
  );
endinterface

// File: rtl/servo_pwm_capture.sv
// Servo PWM receiver: measures high time and rising-to-rising period of pwm_in
// and converts the high time back to a 0..180 degree angle with a serial divider.
module servo_pwm_capture #(
  parameter int MIN_PULSE      = 50_000,
  parameter int CYCLES_PER_DEG = 278,
  parameter int TIMEOUT        = 2_000_000,
  parameter int CNT_W          = 21
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  servo_pwm_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] MIN_W        = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] MAX_W        = CNT_W'(MIN_PULSE + 180 * CYCLES_PER_DEG);
  localparam logic [CNT_W-1:0] CPD_W        = CNT_W'(CYCLES_PER_DEG);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]       ANGLE_MAX    = 8'd180;
  localparam logic [7:0]       ANGLE_RESET  = 8'd90;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_HIGH,
    ST_LOW
  } state_t;

  // pwm_sync[0] and [1] resynchronise the pin, [2] is the previous synced value.
  logic [2:0] pwm_sync;
  logic       rise;
  logic       fall;

  // NOTE: the resync chain resets to all-ones so a pin that is already high when
  // reset releases never looks like a rising edge; its partial pulse is discarded.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) pwm_sync <= 3'b111;
    else          pwm_sync <= {pwm_sync[1:0], bus.pwm_in};
  end

  assign rise = pwm_sync[1] & ~pwm_sync[2];
  assign fall = ~pwm_sync[1] & pwm_sync[2];

  state_t           state;
  logic [CNT_W-1:0] width_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] div_width;
  logic [7:0]       quo;
  logic             div_run;

  logic [7:0]       angle_q;
  logic             valid_q;
  logic [CNT_W-1:0] pulse_width_q;
  logic [CNT_W-1:0] period_q;
  logic             err_range_q;
  logic             err_timeout_q;
  logic             busy_q;

  // NOTE: all state below uses non-blocking assignments; later assignments in the
  // block intentionally override earlier ones (new pulse and timeout beat the divider).
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_SYNC;
      width_cnt     <= '0;
      period_cnt    <= '0;
      idle_cnt      <= '0;
      rem           <= '0;
      div_width     <= '0;
      quo           <= '0;
      div_run       <= 1'b0;
      angle_q       <= ANGLE_RESET;
      valid_q       <= 1'b0;
      pulse_width_q <= '0;
      period_q      <= '0;
      err_range_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      if (rise || fall)         idle_cnt   <= '0;
      else if (idle_cnt != '1)  idle_cnt   <= idle_cnt + 1'b1;
      if (width_cnt != '1)      width_cnt  <= width_cnt + 1'b1;
      if (period_cnt != '1)     period_cnt <= period_cnt + 1'b1;

      // Restoring division: one subtraction of CYCLES_PER_DEG per cycle.
      if (div_run) begin
        if (rem >= CPD_W) begin
          rem <= rem - CPD_W;
          quo <= quo + 8'd1;
        end else begin
          angle_q       <= quo;
          pulse_width_q <= div_width;
          err_range_q   <= 1'b0;
          valid_q       <= 1'b1;
          err_timeout_q <= 1'b0;
          busy_q        <= 1'b0;
          div_run       <= 1'b0;
        end
      end

      case (state)
        ST_SYNC: begin
          if (rise) begin
            state      <= ST_HIGH;
            width_cnt  <= CNT_W'(1);
            period_cnt <= CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state <= ST_LOW;
            if (width_cnt < MIN_W || width_cnt > MAX_W) begin
              angle_q       <= (width_cnt < MIN_W) ? 8'd0 : ANGLE_MAX;
              pulse_width_q <= width_cnt;
              err_range_q   <= 1'b1;
              valid_q       <= 1'b1;
              err_timeout_q <= 1'b0;
              busy_q        <= 1'b0;
              div_run       <= 1'b0;
            end else begin
              rem       <= width_cnt - MIN_W;
              quo       <= 8'd0;
              div_width <= width_cnt;
              div_run   <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
        end
        ST_LOW: begin
          if (rise) begin
            state      <= ST_HIGH;
            width_cnt  <= CNT_W'(1);
            period_q   <= period_cnt;
            period_cnt <= CNT_W'(1);
          end
        end
        default: state <= ST_SYNC;
      endcase

      if (state != ST_SYNC && !rise && !fall && idle_cnt == TIMEOUT_LAST) begin
        state         <= ST_SYNC;
        err_timeout_q <= 1'b1;
        div_run       <= 1'b0;
        busy_q        <= 1'b0;
      end
    end
  end

  assign bus.angle       = angle_q;
  assign bus.angle_valid = valid_q;
  assign bus.pulse_width = pulse_width_q;
  assign bus.period      = period_q;
  assign bus.err_range   = err_range_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Bench for servo_pwm_capture with scaled-down timing; results are compared
// against expectations from a table and from a plain arithmetic reference model.
module tb_servo_pwm_capture;

  localparam int MIN_PULSE = 500;
  localparam int CPD       = 3;
  localparam int TIMEOUT   = 4000;
  localparam int CNT_W     = 12;
  localparam int MAX_PULSE = MIN_PULSE + 180 * CPD;

  logic CLOCK_50 = 1'b0;
  logic reset_n  = 1'b0;

  servo_pwm_capture_if #(.CNT_W(CNT_W)) bus ();

  servo_pwm_capture #(
    .MIN_PULSE      (MIN_PULSE),
    .CYCLES_PER_DEG (CPD),
    .TIMEOUT        (TIMEOUT),
    .CNT_W          (CNT_W)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int angle;
    int pw;
    int err;
    int period;
  } obs_t;

  typedef struct {
    int high;
    int low;
    int exp_angle;
    int exp_err;
  } vec_t;

  obs_t obs_q[$];
  int   busy_cnt = 0;

  always @(negedge CLOCK_50) begin
    if (bus.busy) busy_cnt <= busy_cnt + 1;
    if (bus.angle_valid)
      obs_q.push_back('{int'(bus.angle), int'(bus.pulse_width),
                        int'(bus.err_range), int'(bus.period)});
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model state: the period register only changes on a rising edge
  // that follows another rising edge seen since the last reset/timeout.
  int exp_period = 0;
  bit in_sync    = 1'b0;
  int prev_len   = 0;
  int last_angle = 90;

  function automatic int ref_angle(input int w);
    if (w < MIN_PULSE) return 0;
    if (w > MAX_PULSE) return 180;
    return (w - MIN_PULSE) / CPD;
  endfunction

  function automatic int ref_err(input int w);
    return (w < MIN_PULSE || w > MAX_PULSE) ? 1 : 0;
  endfunction

  task automatic drive(input logic lvl, input int n);
    bus.pwm_in = lvl;
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic do_pulse(input string name, input int h, input int l,
                          input int exp_angle, input int exp_err);
    int   rd0;
    int   b0;
    obs_t o;
    rd0 = obs_q.size();
    b0  = busy_cnt;
    if (in_sync) exp_period = prev_len;
    drive(1'b1, h);
    drive(1'b0, l);
    in_sync  = 1'b1;
    prev_len = h + l;
    check({name, " strobes"}, obs_q.size() - rd0, 1);
    if (obs_q.size() > rd0) begin
      o = obs_q[rd0];
      check({name, " angle"},  o.angle,  exp_angle);
      check({name, " width"},  o.pw,     h);
      check({name, " err"},    o.err,    exp_err);
      check({name, " period"}, o.period, exp_period);
    end
    check({name, " busy cycles"}, busy_cnt - b0, exp_err ? 0 : exp_angle + 1);
    check({name, " timeout clr"}, int'(bus.err_timeout), 0);
    last_angle = exp_angle;
  endtask

  task automatic check_reset_values(input string name);
    check({name, " angle"},   int'(bus.angle),       90);
    check({name, " valid"},   int'(bus.angle_valid), 0);
    check({name, " width"},   int'(bus.pulse_width), 0);
    check({name, " period"},  int'(bus.period),      0);
    check({name, " err_rng"}, int'(bus.err_range),   0);
    check({name, " err_to"},  int'(bus.err_timeout), 0);
    check({name, " busy"},    int'(bus.busy),        0);
  endtask

  vec_t vecs[10];

  initial begin
    int   rd0;
    obs_t o;

    vecs[0] = '{750,  600, 83,  0};
    vecs[1] = '{500,  400, 0,   0};
    vecs[2] = '{1040, 500, 180, 0};
    vecs[3] = '{400,  450, 0,   1};
    vecs[4] = '{1200, 500, 180, 1};
    vecs[5] = '{499,  400, 0,   1};
    vecs[6] = '{1041, 400, 180, 1};
    vecs[7] = '{502,  350, 0,   0};
    vecs[8] = '{503,  350, 1,   0};
    vecs[9] = '{650,  400, 50,  0};

    bus.pwm_in = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    check_reset_values("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge CLOCK_50);

    for (int i = 0; i < 10; i++)
      do_pulse($sformatf("vec%0d", i), vecs[i].high, vecs[i].low,
               vecs[i].exp_angle, vecs[i].exp_err);

    // Long low: timeout sets, angle holds, and the following pulse clears it.
    rd0 = obs_q.size();
    drive(1'b0, TIMEOUT + 200);
    check("timeout flag",    int'(bus.err_timeout), 1);
    check("timeout angle",   int'(bus.angle),       last_angle);
    check("timeout busy",    int'(bus.busy),        0);
    check("timeout strobes", obs_q.size() - rd0,    0);
    in_sync = 1'b0;
    do_pulse("after timeout", 775, 500, 91, 0);

    // Reset released with the pin high: the partial pulse yields no strobe.
    reset_n    = 1'b0;
    bus.pwm_in = 1'b1;
    #1;
    check_reset_values("mid reset");
    repeat (3) @(negedge CLOCK_50);
    reset_n    = 1'b1;
    exp_period = 0;
    in_sync    = 1'b0;
    last_angle = 90;
    rd0 = obs_q.size();
    drive(1'b1, 700);
    drive(1'b0, 600);
    check("partial pulse strobes", obs_q.size() - rd0, 0);
    do_pulse("first full pulse", 650, 400, 50, 0);

    // New falling edge while the divider is busy: only the newer pulse reports.
    rd0 = obs_q.size();
    drive(1'b1, 1040);
    drive(1'b0, 20);
    drive(1'b1, 30);
    drive(1'b0, 600);
    check("abort strobes", obs_q.size() - rd0, 1);
    if (obs_q.size() > rd0) begin
      o = obs_q[rd0];
      check("abort angle",  o.angle,  0);
      check("abort width",  o.pw,     30);
      check("abort err",    o.err,    1);
      check("abort period", o.period, 1060);
    end
    in_sync  = 1'b1;
    prev_len = 630;

    for (int i = 0; i < 14; i++) begin
      int h;
      int l;
      h = int'($urandom_range(1160, 380));
      l = int'($urandom_range(900, 300));
      do_pulse($sformatf("rand%0d w=%0d", i, h), h, l, ref_angle(h), ref_err(h));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
